// File: rtl/learning_pkg.sv
// Shared types and constants for the learning-mode note fetch path.
package learning_pkg;

    localparam logic [3:0] NOTE_REST = 4'h0;
    localparam logic [3:0] NOTE_END  = 4'hF;

    localparam int unsigned DUR_W = 26;
    localparam int unsigned LOC_W = 5;
    localparam logic [2:0]  DCODE_MAX = 3'd5;
    localparam logic [DUR_W-1:0] DUR_MAX = 26'h3FF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } fetch_state_e;

    // Code 0 behaves as one unit; codes above DCODE_MAX would overflow 26 bits.
    function automatic logic [2:0] dcode_clip(input logic [2:0] d);
        logic [2:0] r;
        if (d == 3'd0) begin
            r = 3'd1;
        end else if (d > DCODE_MAX) begin
            r = DCODE_MAX;
        end else begin
            r = d;
        end
        return r;
    endfunction

    function automatic logic [DUR_W-1:0] sat_dur(input logic [32:0] v);
        logic [DUR_W-1:0] r;
        if (v > {7'd0, DUR_MAX}) begin
            r = DUR_MAX;
        end else begin
            r = v[DUR_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/learning_song_rom.sv
// Song ROM: 4 songs x 32 entries of {note[3:0], dcode[2:0]}, one-cycle read latency.
module learning_song_rom
    import learning_pkg::*;
(
    input  logic       clk,
    input  logic [6:0] addr_i,
    output logic [6:0] data_o
);

    logic [6:0] rom_s;
    logic [6:0] data_q;

    // Song table; every unlisted entry is the end marker.
    always_comb begin
        rom_s = {NOTE_END, 3'd0};
        case (addr_i)
            7'd0:    rom_s = {4'd1,  3'd2};
            7'd1:    rom_s = {4'd3,  3'd0};
            7'd2:    rom_s = {4'd5,  3'd7};
            7'd3:    rom_s = {NOTE_REST, 3'd4};
            7'd4:    rom_s = {4'd8,  3'd5};
            7'd5:    rom_s = {4'd14, 3'd1};
            7'd32:   rom_s = {4'd2,  3'd3};
            7'd33:   rom_s = {4'd7,  3'd6};
            7'd64:   rom_s = {4'd12, 3'd1};
            7'd65:   rom_s = {4'd10, 3'd2};
            default: rom_s = {NOTE_END, 3'd0};
        endcase
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        data_q <= rom_s;
    end

    assign data_o = data_q;

endmodule

// File: rtl/learning_note_fetch.sv
// Fetches note/duration for the requested song location and holds them with a valid flag.
// Optional tempo scaling input enabled by defining LEARNING_TEMPO_SCALE_EN.
module learning_note_fetch
    import learning_pkg::*;
#(
    parameter int unsigned DUR_UNIT = 12_500_000,
    parameter int unsigned SONG_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       song_select,
    input  logic [LOC_W-1:0] location,
`ifdef LEARNING_TEMPO_SCALE_EN
    input  logic [1:0]       tempo,
`endif
    output logic [3:0]       note_value,
    output logic [DUR_W-1:0] duration_value,
    output logic             isvalid,
    output logic             song_done
);

    logic [1:0]       tempo_s;
    logic [8:0]       req_s;
    logic [8:0]       req_q;
    logic [8:0]       addr_q;
    logic             change_s;
    fetch_state_e     state_q, state_d;
    logic [1:0]       song_eff_s;
    logic [6:0]       rom_data_s;
    logic [3:0]       rom_note_s;
    logic [31:0]      prod_s;
    logic [32:0]      scaled_s;
    logic [DUR_W-1:0] dur_s;
    logic [3:0]       note_q, note_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

`ifdef LEARNING_TEMPO_SCALE_EN
    assign tempo_s = tempo;
`else
    assign tempo_s = 2'd0;
`endif

    assign req_s    = {tempo_s, song_select, location};
    assign change_s = (req_q != addr_q);

    // Request sample stage; it also tracks inputs during reset so the first fetch uses them.
    always_ff @(posedge clk) begin
        req_q <= req_s;
    end

    // State register plus the address of the fetch in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 9'd0;
        end else begin
            state_q <= state_d;
            if (state_d == S_FETCH) begin
                addr_q <= req_q;
            end else begin
                addr_q <= addr_q;
            end
        end
    end

    // Next-state logic: any pending change restarts the fetch with the newest request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = change_s ? S_FETCH : S_LOAD;
            S_LOAD: begin
                if (change_s) begin
                    state_d = S_FETCH;
                end else if (rom_note_s == NOTE_END) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD, S_DONE: state_d = change_s ? S_FETCH : state_q;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if ({30'd0, addr_q[6:5]} < SONG_CNT) begin
            song_eff_s = addr_q[6:5];
        end else begin
            song_eff_s = 2'd0;
        end
    end

    learning_song_rom u_rom (
        .clk    (clk),
        .addr_i ({song_eff_s, addr_q[4:0]}),
        .data_o (rom_data_s)
    );

    assign rom_note_s = rom_data_s[6:3];

    // Duration decode and tempo scaling of the word being loaded.
    always_comb begin
        prod_s = 32'(dcode_clip(rom_data_s[2:0])) * DUR_UNIT;
`ifdef LEARNING_TEMPO_SCALE_EN
        case (addr_q[8:7])
            2'd1:    scaled_s = {prod_s, 1'b0};
            2'd2:    scaled_s = {2'b00, prod_s[31:1]};
            default: scaled_s = {1'b0, prod_s};
        endcase
`else
        scaled_s = {1'b0, prod_s};
`endif
        dur_s = sat_dur(scaled_s);
    end

    // Output next-values; valid/done drop as soon as a new fetch is pending.
    always_comb begin
        note_d  = note_q;
        dur_d   = dur_q;
        valid_d = valid_q;
        done_d  = done_q;
        case (state_q)
            S_LOAD: begin
                if (change_s) begin
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end else if (rom_note_s == NOTE_END) begin
                    note_d  = NOTE_REST;
                    dur_d   = 26'd0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    note_d  = rom_note_s;
                    dur_d   = dur_s;
                    valid_d = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_HOLD, S_DONE: begin
                if (change_s) begin
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    valid_d = valid_q;
                    done_d  = done_q;
                end
            end
            default: begin
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            note_q  <= 4'd0;
            dur_q   <= 26'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            note_q  <= note_d;
            dur_q   <= dur_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign note_value     = note_q;
    assign duration_value = dur_q;
    assign isvalid        = valid_q;
    assign song_done      = done_q;

endmodule

// File: tb/tb_learning_note_fetch.sv
// Directed, table-driven bench for learning_note_fetch (tempo cases under LEARNING_TEMPO_SCALE_EN).
module tb_learning_note_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  song_select;
    logic [4:0]  location;
    logic [3:0]  note_value;
    logic [25:0] duration_value;
    logic        isvalid;
    logic        song_done;
`ifdef LEARNING_TEMPO_SCALE_EN
    logic [1:0]  tempo;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    learning_note_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .song_select    (song_select),
        .location       (location),
`ifdef LEARNING_TEMPO_SCALE_EN
        .tempo          (tempo),
`endif
        .note_value     (note_value),
        .duration_value (duration_value),
        .isvalid        (isvalid),
        .song_done      (song_done)
    );

    typedef struct {
        logic [1:0]  song;
        logic [4:0]  loc;
        logic [3:0]  note;
        logic [25:0] dur;
        logic        valid;
        logic        done;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] n, input logic [25:0] d,
                             input logic v, input logic sd);
        check({name, ".note"},  {28'd0, note_value},     {28'd0, n});
        check({name, ".dur"},   {6'd0, duration_value},  {6'd0, d});
        check({name, ".valid"}, {31'd0, isvalid},        {31'd0, v});
        check({name, ".done"},  {31'd0, song_done},      {31'd0, sd});
    endtask

    // Apply a request change and check the N+1 drop and the N+3 result.
    task automatic apply(input string name, input logic [1:0] s, input logic [4:0] l,
                         input logic [3:0] n, input logic [25:0] d, input logic v, input logic sd);
        song_select = s;
        location    = l;
        tick();
        tick();
        check({name, ".drop"}, {31'd0, isvalid}, 32'd0);
        tick();
        check({name, ".mid"}, {31'd0, isvalid}, 32'd0);
        tick();
        check_out(name, n, d, v, sd);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 5'd1,  4'd3,  26'd12_500_000, 1'b1, 1'b0};
        vecs[1]  = '{2'd0, 5'd2,  4'd5,  26'd62_500_000, 1'b1, 1'b0};
        vecs[2]  = '{2'd0, 5'd3,  4'd0,  26'd50_000_000, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 5'd4,  4'd8,  26'd62_500_000, 1'b1, 1'b0};
        vecs[4]  = '{2'd0, 5'd5,  4'd14, 26'd12_500_000, 1'b1, 1'b0};
        vecs[5]  = '{2'd0, 5'd6,  4'd0,  26'd0,          1'b0, 1'b1};
        vecs[6]  = '{2'd0, 5'd0,  4'd1,  26'd25_000_000, 1'b1, 1'b0};
        vecs[7]  = '{2'd1, 5'd0,  4'd2,  26'd37_500_000, 1'b1, 1'b0};
        vecs[8]  = '{2'd1, 5'd1,  4'd7,  26'd62_500_000, 1'b1, 1'b0};
        vecs[9]  = '{2'd2, 5'd0,  4'd12, 26'd12_500_000, 1'b1, 1'b0};
        vecs[10] = '{2'd2, 5'd1,  4'd10, 26'd25_000_000, 1'b1, 1'b0};
        vecs[11] = '{2'd3, 5'd1,  4'd3,  26'd12_500_000, 1'b1, 1'b0};
        vecs[12] = '{2'd0, 5'd31, 4'd0,  26'd0,          1'b0, 1'b1};
        vecs[13] = '{2'd0, 5'd0,  4'd1,  26'd25_000_000, 1'b1, 1'b0};
        vecs[14] = '{2'd1, 5'd2,  4'd0,  26'd0,          1'b0, 1'b1};

        rst         = 1'b1;
        song_select = 2'd0;
        location    = 5'd0;
`ifdef LEARNING_TEMPO_SCALE_EN
        tempo       = 2'd0;
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("reset", 4'd0, 26'd0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        tick();
        check("boot.c1", {31'd0, isvalid}, 32'd0);
        tick();
        check("boot.c2", {31'd0, isvalid}, 32'd0);
        tick();
        check_out("boot.c3", 4'd1, 26'd25_000_000, 1'b1, 1'b0);

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].song, vecs[i].loc,
                  vecs[i].note, vecs[i].dur, vecs[i].valid, vecs[i].done);
        end

        // Back to song 0 entry 0, then two consecutive location changes: 3 then 4.
        apply("settle", 2'd0, 5'd0, 4'd1, 26'd25_000_000, 1'b1, 1'b0);
        location = 5'd3;
        tick();
        location = 5'd4;
        tick();
        check("dbl.m0", {31'd0, isvalid}, 32'd0);
        tick();
        check("dbl.m1", {31'd0, isvalid}, 32'd0);
        tick();
        check("dbl.m2", {31'd0, isvalid}, 32'd0);
        tick();
        check_out("dbl.m3", 4'd8, 26'd62_500_000, 1'b1, 1'b0);

        // Reset in the middle of a fetch clears outputs on the next edge.
        location = 5'd5;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_out("rstmid", 4'd0, 26'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        check("rstmid.c2", {31'd0, isvalid}, 32'd0);
        tick();
        check_out("rstmid.c3", 4'd14, 26'd12_500_000, 1'b1, 1'b0);

`ifdef LEARNING_TEMPO_SCALE_EN
        apply("t0.l4", 2'd0, 5'd4, 4'd8, 26'd62_500_000, 1'b1, 1'b0);
        tempo = 2'd1;
        tick();
        tick();
        check("t1.drop", {31'd0, isvalid}, 32'd0);
        tick();
        tick();
        check_out("t1.sat", 4'd8, 26'd67_108_863, 1'b1, 1'b0);
        tempo = 2'd2;
        tick();
        tick();
        tick();
        tick();
        check_out("t2.half", 4'd8, 26'd31_250_000, 1'b1, 1'b0);
        tempo = 2'd3;
        tick();
        tick();
        tick();
        tick();
        check_out("t3.unit", 4'd8, 26'd62_500_000, 1'b1, 1'b0);
        tempo = 2'd1;
        apply("t1.l0", 2'd0, 5'd0, 4'd1, 26'd50_000_000, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
